// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state type for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_ST_RD,
        S_ST_WR,
        S_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load extraction/extension, store lane merge and request error decode
module lsu_align
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data,
    output logic        o_err
);

    localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_range_err;
    logic        w_align_err;
    logic        w_f3_err;

    always_comb begin
        w_byte = i_rdata[{i_addr[1:0], 3'b000} +: 8];
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = '0;
        endcase

        // Only the addressed lane(s) change; the rest of the word is preserved.
        o_merge_data = i_rdata;
        if (i_funct3 == F3_B) begin
            o_merge_data[{i_addr[1:0], 3'b000} +: 8] = i_wdata[7:0];
        end else if (i_funct3 == F3_H) begin
            if (i_addr[1]) begin
                o_merge_data[31:16] = i_wdata;
            end else begin
                o_merge_data[15:0] = i_wdata;
            end
        end

        w_range_err = ({2'b00, i_addr[31:2]} >= LP_WORDS);
        w_align_err = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr[0])
                   || ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
        if (i_we) begin
            w_f3_err = !((i_funct3 == F3_B) || (i_funct3 == F3_H) || (i_funct3 == F3_W));
        end else begin
            w_f3_err = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111);
        end
        o_err = w_range_err || w_align_err || w_f3_err;
    end

endmodule

// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - single-outstanding load/store unit with read-modify-write for sub-word stores
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_idle;
    logic        w_accept;
    logic        w_al_we;
    logic [2:0]  w_al_funct3;
    logic [31:0] w_al_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;
    logic        w_err;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && i_req_valid;

    // Error decode looks at the live request in IDLE; data paths use the latched request.
    assign w_al_we     = w_idle ? i_req_we     : r_we;
    assign w_al_funct3 = w_idle ? i_req_funct3 : r_funct3;
    assign w_al_addr   = w_idle ? i_req_addr   : r_addr;

    lsu_align #(.MEM_WORDS(MEM_WORDS)) u_align (
        .i_we         (w_al_we),
        .i_funct3     (w_al_funct3),
        .i_addr       (w_al_addr),
        .i_wdata      (r_wdata[15:0]),
        .i_rdata      (i_mem_rdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data),
        .o_err        (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_wdata  = '0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    if (w_err)                     w_next = S_RESP;
                    else if (!i_req_we)            w_next = S_LD;
                    else if (i_req_funct3 == F3_W) w_next = S_ST_WR;
                    else                           w_next = S_ST_RD;
                end
            end
            S_LD: begin
                o_mem_read = 1'b1;
                w_next     = S_RESP;
            end
            S_ST_RD: begin
                o_mem_read = 1'b1;
                w_next     = S_ST_WR;
            end
            S_ST_WR: begin
                o_mem_write = 1'b1;
                o_mem_wdata = (r_funct3 == F3_W) ? r_wdata : r_merge;
                w_next      = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                if (i_resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_err    <= w_err;
                r_rdata  <= '0;
            end
            if (r_state == S_LD)    r_rdata <= w_load_data;
            if (r_state == S_ST_RD) r_merge <= w_merge_data;
        end
    end

    assign o_mem_addr   = {r_addr[31:2], 2'b00};
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - scoreboard-driven bench for lsu_rmw
module tb_lsu_rmw;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b1;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    always #5 clk = ~clk;

    lsu_rmw #(.MEM_WORDS(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_resp_rdata (o_resp_rdata),
        .o_resp_err   (o_resp_err),
        .o_mem_read   (o_mem_read),
        .o_mem_write  (o_mem_write),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata)
    );

    // Word-addressed memory model, cleared on reset like the real array.
    logic [31:0] mem [0:1023];
    assign i_mem_rdata = (o_mem_addr[31:12] == 20'd0) ? mem[o_mem_addr[11:2]] : 32'hDEAD0000;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (o_mem_write && (o_mem_addr[31:12] == 20'd0)) begin
            mem[o_mem_addr[11:2]] <= o_mem_wdata;
        end
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_wdata = '0;
    always @(negedge clk) begin
        if (o_mem_read) rd_cnt++;
        if (o_mem_write) begin
            wr_cnt++;
            last_wdata = o_mem_wdata;
        end
        if (o_mem_read && o_mem_write) both_cnt++;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb_q[$];

    int tests = 0;
    int fails = 0;

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] e_rdata, input logic e_err,
                           input int e_lat, input int e_nrd, input int e_nwr,
                           input logic [31:0] e_wdata, input string name);
        exp_t e;
        exp_t got;
        int   k;
        e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
        e.nrd = e_nrd; e.nwr = e_nwr; e.wdata = e_wdata;
        @(negedge clk);
        tests++;
        if (o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s req_ready before request: got %b want 1", name, o_req_ready);
        end
        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
        i_req_addr = addr; i_req_wdata = wdata;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (o_resp_valid === 1'b1) break;
        end
        got = sb_q.pop_front();
        tests++;
        if (o_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s timeout: resp_valid=%b after %0d cycles, want 1", name, o_resp_valid, k);
            return;
        end
        tests++;
        if (k != got.lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, k, got.lat);
        end
        tests++;
        if (o_resp_rdata !== got.rdata) begin
            fails++;
            $display("FAIL %s rdata: got %h want %h", name, o_resp_rdata, got.rdata);
        end
        tests++;
        if (o_resp_err !== got.err) begin
            fails++;
            $display("FAIL %s err: got %b want %b", name, o_resp_err, got.err);
        end
        tests++;
        if (rd_cnt != got.nrd || wr_cnt != got.nwr) begin
            fails++;
            $display("FAIL %s mem cycles: got rd=%0d wr=%0d want rd=%0d wr=%0d",
                     name, rd_cnt, wr_cnt, got.nrd, got.nwr);
        end
        if (got.nwr > 0) begin
            tests++;
            if (last_wdata !== got.wdata) begin
                fails++;
                $display("FAIL %s mem_wdata: got %h want %h", name, last_wdata, got.wdata);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s release: got valid=%b ready=%b want 0/1", name, o_resp_valid, o_req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (o_resp_valid !== 1'b0 || o_resp_rdata !== 32'd0 || o_resp_err !== 1'b0 ||
            o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_mem_addr !== 32'd0 ||
            o_mem_wdata !== 32'd0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s outputs: got v=%b d=%h e=%b rd=%b wr=%b a=%h wd=%h rdy=%b want reset values",
                     name, o_resp_valid, o_resp_rdata, o_resp_err, o_mem_read, o_mem_write,
                     o_mem_addr, o_mem_wdata, o_req_ready);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("reset_release");
    endtask

    task automatic test_loads();
        run_req(1'b1, F3_W,  32'h10, 32'h8899AABB, 32'h0, 1'b0, 2, 0, 1, 32'h8899AABB, "sw_w4");
        run_req(1'b0, F3_B,  32'h12, 32'h0, 32'hFFFFFF99, 1'b0, 2, 1, 0, 32'h0, "lb_12");
        run_req(1'b0, F3_BU, 32'h12, 32'h0, 32'h00000099, 1'b0, 2, 1, 0, 32'h0, "lbu_12");
        run_req(1'b0, F3_HU, 32'h12, 32'h0, 32'h00008899, 1'b0, 2, 1, 0, 32'h0, "lhu_12");
        run_req(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1, 0, 32'h0, "lh_12");
        run_req(1'b0, F3_B,  32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1, 0, 32'h0, "lb_10");
        run_req(1'b0, F3_W,  32'h10, 32'h0, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h0, "lw_10");
        run_req(1'b0, F3_W,  32'hFFC, 32'h0, 32'h0, 1'b0, 2, 1, 0, 32'h0, "lw_last_word");
    endtask

    task automatic test_sb();
        run_req(1'b1, F3_W, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, 0, 1, 32'h11223344, "sw_w4b");
        run_req(1'b1, F3_B, 32'h11, 32'h000000EE, 32'h0, 1'b0, 3, 1, 1, 32'h1122EE44, "sb_11");
        run_req(1'b0, F3_W, 32'h10, 32'h0, 32'h1122EE44, 1'b0, 2, 1, 0, 32'h0, "lw_after_sb");
    endtask

    task automatic test_sh_sw();
        run_req(1'b1, F3_H, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1, 32'hBEEF0000, "sh_22");
        run_req(1'b0, F3_W, 32'h20, 32'h0, 32'hBEEF0000, 1'b0, 2, 1, 0, 32'h0, "lw_after_sh");
        run_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF, "sw_20");
        run_req(1'b0, F3_W, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 32'h0, "lw_after_sw");
    endtask

    task automatic test_errors();
        run_req(1'b0, F3_W,   32'h06,   32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, "err_lw_06");
        run_req(1'b1, F3_H,   32'h03,   32'h1234, 32'h0, 1'b1, 1, 0, 0, 32'h0, "err_sh_03");
        run_req(1'b0, F3_W,   32'h1000, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, "err_lw_range");
        run_req(1'b0, 3'b011, 32'h10,   32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, "err_ld_f3");
        run_req(1'b1, F3_BU,  32'h10,   32'h5, 32'h0, 1'b1, 1, 0, 0, 32'h0, "err_st_f3");
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t got;
        int   k;
        e.rdata = 32'hDEADBEEF; e.err = 1'b0; e.lat = 2; e.nrd = 1; e.nwr = 0; e.wdata = 32'h0;
        @(negedge clk);
        i_resp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = F3_W; i_req_addr = 32'h20;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (o_resp_valid === 1'b1) break;
        end
        got = sb_q.pop_front();
        tests++;
        if (o_resp_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp timeout: resp_valid=%b want 1", o_resp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== got.rdata || o_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cycle %0d: got v=%b d=%h rdy=%b want 1/%h/0",
                         c, o_resp_valid, o_resp_rdata, o_req_ready, got.rdata);
            end
        end
        i_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got v=%b rdy=%b want 0/1", o_resp_valid, o_req_ready);
        end
        run_req(1'b0, F3_BU, 32'h23, 32'h0, 32'h000000DE, 1'b0, 2, 1, 0, 32'h0, "lbu_after_bp");
    endtask

    task automatic test_reset_mid();
        exp_t e;
        e.rdata = 32'h0; e.err = 1'b0; e.lat = 3; e.nrd = 1; e.nwr = 1; e.wdata = 32'h0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = F3_B;
        i_req_addr = 32'h11; i_req_wdata = 32'h55;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        wr_cnt = 0;
        @(negedge clk);
        tests++;
        if (o_mem_read !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid in ST_RD: mem_read=%b want 1", o_mem_read);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid_async");
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("rst_mid_release");
        tests++;
        if (wr_cnt != 0) begin
            fails++;
            $display("FAIL rst_mid write: got %0d write cycles want 0", wr_cnt);
        end
        run_req(1'b0, F3_W, 32'h10, 32'h0, 32'h0, 1'b0, 2, 1, 0, 32'h0, "lw_after_rst");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sb();
        test_sh_sw();
        test_errors();
        test_backpressure();
        test_reset_mid();
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL rd_wr_exclusive: got %0d overlapping cycles want 0", both_cnt);
        end
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
